// File: rtl/pwm_unit.sv
// Single-channel counter-based PWM generator with double-buffered period and duty.
// Range and value are latched into shadow registers only at a period boundary or while idle.
module pwm_unit #(
  parameter int WIDTH = 8
) (
  input  logic             pwm_clk,
  input  logic             pwm_reset,
  input  logic             pwm_en,
  input  logic [WIDTH-1:0] pwm_value,
  input  logic [WIDTH-1:0] pwm_range,
  output logic             pwm_out,
  output logic             pwm_period
);

  logic             run;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] val_sh;
  logic [WIDTH-1:0] rng_sh;
  logic             at_tc;
  logic             active;

  assign at_tc  = (cnt == rng_sh);
  assign active = run & pwm_en;

  // Shadows reload whenever idle or at terminal count, so a new period always
  // starts with the inputs sampled at the edge that begins it.
  always_ff @(posedge pwm_clk or negedge pwm_reset) begin
    if (!pwm_reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      val_sh <= '0;
      rng_sh <= '0;
    end else begin
      run <= pwm_en;
      if (!active) begin
        cnt    <= '0;
        val_sh <= pwm_value;
        rng_sh <= pwm_range;
      end else if (at_tc) begin
        cnt    <= '0;
        val_sh <= pwm_value;
        rng_sh <= pwm_range;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  // Register-only decode; val_sh > rng_sh naturally yields 100% duty.
  assign pwm_out    = run & (cnt < val_sh);
  assign pwm_period = run & at_tc;

endmodule

// File: tb/tb_pwm_unit.sv
// Randomized and directed bench for pwm_unit; a period-level reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_pwm_unit;

  localparam int WIDTH = 8;

  logic             pwm_clk;
  logic             pwm_reset;
  logic             pwm_en;
  logic [WIDTH-1:0] pwm_value;
  logic [WIDTH-1:0] pwm_range;
  logic             pwm_out;
  logic             pwm_period;

  int checks;
  int errors;

  logic [1:0] sb[$];    // expected {out, period} per cycle
  logic [1:0] pend[$];  // remaining cycles of the current reference period
  logic       run_m;

  pwm_unit #(.WIDTH(WIDTH)) dut (
    .pwm_clk    (pwm_clk),
    .pwm_reset  (pwm_reset),
    .pwm_en     (pwm_en),
    .pwm_value  (pwm_value),
    .pwm_range  (pwm_range),
    .pwm_out    (pwm_out),
    .pwm_period (pwm_period)
  );

  initial pwm_clk = 1'b0;
  always #5 pwm_clk = ~pwm_clk;

  // A whole period: rng+1 cycles, high for the first val, marker on the last.
  function automatic void new_period(input int val, input int rng);
    pend.delete();
    for (int i = 0; i <= rng; i++) begin
      pend.push_back({(i < val) ? 1'b1 : 1'b0, (i == rng) ? 1'b1 : 1'b0});
    end
  endfunction

  // Reference model: expected outputs for the cycle following each edge.
  always @(posedge pwm_clk) begin
    logic [1:0] e;
    if (!pwm_reset) begin
      run_m = 1'b0;
      pend.delete();
      e = 2'b00;
    end else if (run_m && pwm_en) begin
      void'(pend.pop_front());
      if (pend.size() == 0) new_period(int'(pwm_value), int'(pwm_range));
      e = pend[0];
    end else if (pwm_en) begin
      new_period(int'(pwm_value), int'(pwm_range));
      e = pend[0];
    end else begin
      pend.delete();
      e = 2'b00;
    end
    if (pwm_reset) run_m = pwm_en;
    sb.push_back(e);
  end

  always @(negedge pwm_reset) begin
    run_m = 1'b0;
    pend.delete();
  end

  // Monitor
  always @(negedge pwm_clk) begin
    logic [1:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty t=%0t no expected entry", $time);
    end else begin
      e = sb.pop_front();
      if (!pwm_reset) e = 2'b00;
      if ({pwm_out, pwm_period} !== e) begin
        errors++;
        $display("FAIL wave t=%0t out,period actual=%b required=%b", $time,
                 {pwm_out, pwm_period}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pwm_clk);
    #1;
  endtask

  task automatic set_in(input logic en, input int val, input int rng);
    pwm_en    = en;
    pwm_value = WIDTH'(val);
    pwm_range = WIDTH'(rng);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({pwm_out, pwm_period} !== 2'b00) begin
      errors++;
      $display("FAIL %s t=%0t out,period actual=%b required=00", name, $time,
               {pwm_out, pwm_period});
    end
  endtask

  task automatic reset_pulse(input int hold);
    @(posedge pwm_clk);
    #2;
    pwm_reset = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (hold) @(posedge pwm_clk);
    #3;
    pwm_reset = 1'b1;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    run_m     = 1'b0;
    pwm_reset = 1'b0;
    set_in(1'b0, 0, 0);
    #1;
    check_zero("reset_state");
    #29;
    pwm_reset = 1'b1;
    cyc(2);

    set_in(1'b1, 8'h40, 8'hFF); cyc(600);
    pwm_value = 8'h00;          cyc(520);
    pwm_value = 8'hFF;          cyc(520);
    set_in(1'b1, 5, 3);         cyc(300);
    set_in(1'b1, 1, 0);         cyc(20);

    // value stepped mid-period
    set_in(1'b0, 8'h10, 8'hFF); cyc(2);
    pwm_en = 1'b1;              cyc(100);
    pwm_value = 8'h20;          cyc(600);

    // ramp one step per period
    pwm_en = 1'b0; cyc(2);
    pwm_value = 8'h00;
    pwm_en = 1'b1; cyc(1);
    for (int i = 1; i <= 5; i++) begin
      cyc(256);
      pwm_value = WIDTH'(i);
    end
    cyc(256);

    // disable near cnt=100 and restart
    pwm_en = 1'b0; cyc(2);
    set_in(1'b1, 8'h80, 8'hFF); cyc(101);
    pwm_en = 1'b0; cyc(3);
    pwm_en = 1'b1; cyc(300);

    // reset mid-period, then idle until enabled again
    reset_pulse(0);
    cyc(200);
    reset_pulse(2);
    pwm_en = 1'b0; cyc(5);
    pwm_en = 1'b1; cyc(300);

    // randomized segments with small ranges
    for (int k = 0; k < 60; k++) begin
      set_in(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
             int'($urandom_range(0, 12)), int'($urandom_range(0, 10)));
      if ($urandom_range(0, 14) == 0) reset_pulse(int'($urandom_range(0, 2)));
      cyc(int'($urandom_range(1, 30)));
    end
    set_in(1'b1, 8'hFF, 8'hFF); cyc(260);

    @(negedge pwm_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
